// File: rtl/mul_seq_ctrl_if.sv
// Handshake and operand bundle between the execute stage and the multiply sequencer.
// The execute stage drives operands and control; the sequencer returns stall, done and product.
interface mul_seq_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             start_i;
   logic [3:0]       alu_ctrl_i;
   logic             flush_i;
   logic [WIDTH-1:0] src1_i;
   logic [WIDTH-1:0] src2_i;
   logic             stall_o;
   logic             done_o;
   logic [WIDTH-1:0] result_o;

   modport master (
      output start_i, alu_ctrl_i, flush_i, src1_i, src2_i,
      input  stall_o, done_o, result_o
   );

   modport slave (
      input  start_i, alu_ctrl_i, flush_i, src1_i, src2_i,
      output stall_o, done_o, result_o
   );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Iterative shift-add multiplier sequencer: stalls the pipeline for a MUL, retires one
// multiplier bit per cycle and pulses done with the low WIDTH bits of the product.
module mul_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic           clk_i,
   input logic           rst_i,
   mul_seq_ctrl_if.slave bus
);

   localparam logic [1:0]       IDLE     = 2'b00;
   localparam logic [1:0]       RUN      = 2'b01;
   localparam logic [1:0]       DONE     = 2'b10;
   localparam logic [3:0]       ALU_MUL  = 4'b0011;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   logic [1:0]       state_r,  state_nxt_s;
   logic [WIDTH-1:0] acc_r,    acc_nxt_s;
   logic [WIDTH-1:0] mcand_r,  mcand_nxt_s;
   logic [WIDTH-1:0] mplier_r, mplier_nxt_s;
   logic [CNT_W-1:0] cnt_r,    cnt_nxt_s;
   logic [WIDTH-1:0] result_r, result_nxt_s;
   logic [WIDTH-1:0] acc_step_s;
   logic             is_mul_s;
   logic             launch_s;

   assign is_mul_s   = bus.start_i & (bus.alu_ctrl_i == ALU_MUL);
   assign launch_s   = is_mul_s & ~bus.flush_i;
   assign acc_step_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;

   // Stall must assert in the decode cycle itself, so it is decoded combinationally.
   assign bus.stall_o  = ((state_r == IDLE) & launch_s) | (state_r == RUN);
   assign bus.done_o   = (state_r == DONE);
   assign bus.result_o = result_r;

   // Next-state and datapath update for the three-state sequencer.
   always_comb begin
      state_nxt_s  = state_r;
      acc_nxt_s    = acc_r;
      mcand_nxt_s  = mcand_r;
      mplier_nxt_s = mplier_r;
      cnt_nxt_s    = cnt_r;
      result_nxt_s = result_r;
      case (state_r)
         IDLE: begin
            if (launch_s) begin
               state_nxt_s  = RUN;
               acc_nxt_s    = {WIDTH{1'b0}};
               mcand_nxt_s  = bus.src1_i;
               mplier_nxt_s = bus.src2_i;
               cnt_nxt_s    = {CNT_W{1'b0}};
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (bus.flush_i) begin
               state_nxt_s = IDLE;
            end else begin
               acc_nxt_s    = acc_step_s;
               mcand_nxt_s  = {mcand_r[WIDTH-2:0], 1'b0};
               mplier_nxt_s = {1'b0, mplier_r[WIDTH-1:1]};
               cnt_nxt_s    = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               // The last multiplier bit is folded straight into the published result.
               if (cnt_r == LAST_CNT) begin
                  state_nxt_s  = DONE;
                  result_nxt_s = acc_step_s;
               end else begin
                  state_nxt_s = RUN;
               end
            end
         end
         DONE: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r  <= IDLE;
         acc_r    <= {WIDTH{1'b0}};
         mcand_r  <= {WIDTH{1'b0}};
         mplier_r <= {WIDTH{1'b0}};
         cnt_r    <= {CNT_W{1'b0}};
         result_r <= {WIDTH{1'b0}};
      end else begin
         state_r  <= state_nxt_s;
         acc_r    <= acc_nxt_s;
         mcand_r  <= mcand_nxt_s;
         mplier_r <= mplier_nxt_s;
         cnt_r    <= cnt_nxt_s;
         result_r <= result_nxt_s;
      end
   end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed self-checking bench for mul_seq_ctrl (WIDTH = 32).
module tb_mul_seq_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   int   stall_cnt;
   int   done_cyc;
   int   done_cnt;
   int   first_done;
   int   second_done;

   mul_seq_ctrl_if #(.WIDTH(32)) bus ();

   mul_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Launch a MUL at a negedge (cycle 0) and follow it to done.
   task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
      bus.src1_i     = a;
      bus.src2_i     = b;
      bus.alu_ctrl_i = 4'b0011;
      bus.start_i    = 1'b1;
      #1;
      check({tag, "_stall_c0"}, 64'(bus.stall_o), 64'd1);
      stall_cnt = 0;
      done_cyc  = -1;
      for (int k = 0; k < 45 && done_cyc < 0; k++) begin
         if (k > 0) @(negedge clk);
         if (bus.stall_o) stall_cnt++;
         if (bus.done_o) begin
            done_cyc    = k;
            bus.start_i = 1'b0;
         end
      end
      check({tag, "_done_cycle"}, 64'(done_cyc), 64'd33);
      check({tag, "_stall_cycles"}, 64'(stall_cnt), 64'd33);
      check({tag, "_result"}, 64'(bus.result_o), 64'(exp));
      @(negedge clk);
      check({tag, "_done_after"}, 64'(bus.done_o), 64'd0);
      check({tag, "_stall_after"}, 64'(bus.stall_o), 64'd0);
   endtask

   initial begin
      bus.start_i    = 1'b0;
      bus.alu_ctrl_i = 4'b0000;
      bus.flush_i    = 1'b0;
      bus.src1_i     = 32'd0;
      bus.src2_i     = 32'd0;
      repeat (2) @(negedge clk);
      check("rst_stall", 64'(bus.stall_o), 64'd0);
      check("rst_done", 64'(bus.done_o), 64'd0);
      check("rst_result", 64'(bus.result_o), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      run_mul("basic", 32'd3, 32'd5, 32'd15);
      run_mul("overflow", 32'h8000_0000, 32'd2, 32'h0000_0000);
      run_mul("wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);

      // Non-MUL codes never stall or complete.
      bus.src1_i     = 32'd11;
      bus.src2_i     = 32'd13;
      bus.alu_ctrl_i = 4'b0010;
      bus.start_i    = 1'b1;
      #1;
      check("add_stall", 64'(bus.stall_o), 64'd0);
      done_cnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.done_o || bus.stall_o) done_cnt++;
      end
      bus.alu_ctrl_i = 4'b0111;
      #1;
      check("slt_stall", 64'(bus.stall_o), 64'd0);
      repeat (3) begin
         @(negedge clk);
         if (bus.done_o || bus.stall_o) done_cnt++;
      end
      check("nonmul_activity", 64'(done_cnt), 64'd0);
      check("nonmul_result", 64'(bus.result_o), 64'd1);
      bus.start_i = 1'b0;
      @(negedge clk);

      // Async reset in the middle of cycle 10 of a 7 x 9.
      bus.src1_i     = 32'd7;
      bus.src2_i     = 32'd9;
      bus.alu_ctrl_i = 4'b0011;
      bus.start_i    = 1'b1;
      repeat (10) @(negedge clk);
      check("pre_rst_stall", 64'(bus.stall_o), 64'd1);
      bus.start_i = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_stall", 64'(bus.stall_o), 64'd0);
      check("midrst_done", 64'(bus.done_o), 64'd0);
      check("midrst_result", 64'(bus.result_o), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_mul("after_rst", 32'd6, 32'd7, 32'd42);

      // Flush a 4 x 4 in cycle 5.
      bus.src1_i     = 32'd4;
      bus.src2_i     = 32'd4;
      bus.alu_ctrl_i = 4'b0011;
      bus.start_i    = 1'b1;
      repeat (5) @(negedge clk);
      bus.start_i = 1'b0;
      bus.flush_i = 1'b1;
      #1;
      check("flush_stall_c5", 64'(bus.stall_o), 64'd1);
      @(negedge clk);
      bus.flush_i = 1'b0;
      check("flush_stall_c6", 64'(bus.stall_o), 64'd0);
      done_cnt = 0;
      repeat (40) begin
         if (bus.done_o) done_cnt++;
         @(negedge clk);
      end
      check("flush_no_done", 64'(done_cnt), 64'd0);
      check("flush_result", 64'(bus.result_o), 64'd42);

      // Flush in IDLE suppresses a launch.
      bus.start_i = 1'b1;
      bus.flush_i = 1'b1;
      #1;
      check("idle_flush_stall", 64'(bus.stall_o), 64'd0);
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.flush_i = 1'b0;
      #1;
      check("idle_flush_nolaunch", 64'(bus.stall_o), 64'd0);
      @(negedge clk);

      // Back-to-back 2 x 3 then 10 x 10, issue held high throughout.
      bus.src1_i     = 32'd2;
      bus.src2_i     = 32'd3;
      bus.alu_ctrl_i = 4'b0011;
      bus.start_i    = 1'b1;
      first_done  = -1;
      second_done = -1;
      for (int k = 0; k < 100 && second_done < 0; k++) begin
         if (k > 0) @(negedge clk);
         if (bus.done_o) begin
            if (first_done < 0) begin
               first_done = k;
               check("b2b_first_result", 64'(bus.result_o), 64'd6);
               bus.src1_i = 32'd10;
               bus.src2_i = 32'd10;
            end else begin
               second_done = k;
               check("b2b_second_result", 64'(bus.result_o), 64'd100);
               bus.start_i = 1'b0;
            end
         end
      end
      check("b2b_first_cycle", 64'(first_done), 64'd33);
      check("b2b_spacing", 64'(second_done - first_done), 64'd34);
      @(negedge clk);
      check("b2b_idle_stall", 64'(bus.stall_o), 64'd0);
      check("b2b_result_hold", 64'(bus.result_o), 64'd100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Multi-cycle sequencer for the integer multiply (`mul`) path of the CPU datapath. When the ALU control field selects multiply (4'b0011), it:
- stalls the PC/pipeline,
- computes the low WIDTH bits of src1 × src2 by iterative shift-add, one multiplier bit per cycle,
- pulses done with the product so the register file writes back on the release cycle.

All other ALU operations pass through untouched and never stall.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits (≥ 2)
- CNT_W, 6, iteration counter width (must satisfy 2^CNT_W > WIDTH)

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-high
- start_i  input  1  instruction valid in execute stage this cycle
- alu_ctrl_i  input  4  ALU control code from ALU controller; 4'b0011 = MUL
- flush_i  input  1  synchronous abort of an in-flight multiply
- src1_i  input  WIDTH  multiplicand
- src2_i  input  WIDTH  multiplier
- stall_o  output  1  hold PC/pipeline registers
- done_o  output  1  one-cycle pulse, result_o valid, write-back enable for mul
- result_o  output  WIDTH  product low WIDTH bits; holds last completed value

## Operation
- States: IDLE, RUN, DONE. Registers:
  - `acc` (WIDTH)
  - `mcand` (WIDTH, shifts left)
  - `mplier` (WIDTH, shifts right)
  - `cnt` (CNT_W)
  - `result_o` (WIDTH)
- `is_mul = start_i & (alu_ctrl_i == 4'b0011)`.
- IDLE:
  - If `is_mul`: load `mcand = src1_i`, `mplier = src2_i`, `acc = 0`, `cnt = 0`; go to RUN.
  - Otherwise stay in IDLE. A non-MUL code, or `start_i = 0`, is ignored.
- RUN, each cycle:
  - If `mplier[0]`: `acc = acc + mcand`, truncated to WIDTH bits.
  - Then `mcand <<= 1`, `mplier >>= 1`, `cnt += 1`.
  - When the update makes `cnt == WIDTH`: copy the final `acc` into `result_o` and go to DONE.
- DONE: go to IDLE unconditionally. `start_i` is ignored in DONE, because the stalled mul instruction retires in this cycle.
- Arithmetic is unsigned modulo 2^WIDTH. The low WIDTH bits are identical for signed and unsigned operands, so there is no sign handling.
- No early termination: every RUN phase is exactly WIDTH cycles, even when an operand is zero.
- `stall_o = (state == IDLE & is_mul & ~flush_i) | (state == RUN)`. This is combinational, so the pipeline freezes in the same cycle the mul is decoded.
- `done_o = (state == DONE)`.
- `flush_i`:
  - In RUN: go to IDLE next edge. `result_o` is unchanged and no `done_o` is issued.
  - In IDLE: suppresses a launch. `flush_i` wins over `is_mul`.
  - In DONE: no effect.
- Operand inputs are sampled only on the launch edge; changes during RUN are ignored.
- Reset (any state, any time):
  - state = IDLE
  - `acc`, `mcand`, `mplier`, `cnt` = 0
  - `result_o` = 0
  - `stall_o` = 0 (unless `is_mul` is asserted in IDLE after reset release)
  - `done_o` = 0

## Timing
- Cycle 0: `is_mul` seen in IDLE. `stall_o = 1` combinationally; launch on the edge ending cycle 0.
- Cycles 1..WIDTH: RUN, `stall_o = 1`.
- Cycle WIDTH+1: DONE. `stall_o = 0`, `done_o = 1`, `result_o` valid. The pipeline advances and writes back on the edge ending this cycle.
- Total `stall_o` high: WIDTH+1 cycles. Launch to `done_o`: WIDTH+1 cycles. For WIDTH = 32, `done_o` is in cycle 33.
- Back-to-back muls: a new `is_mul` is accepted in IDLE at cycle WIDTH+2 at the earliest. There is exactly one non-stalled cycle (DONE) between two multiplies.
- `result_o` is stable from DONE until the next completing multiply.

## Test plan
- **Basic multiply:** src1 = 3, src2 = 5, `alu_ctrl_i = 4'b0011`, `start_i = 1` held → `stall_o = 1` for 33 cycles, `done_o` pulse in cycle 33, `result_o = 15`, then IDLE.
- **Wrap-around:** `0xFFFFFFFF × 0xFFFFFFFF` → `result_o = 0x00000001`.
- **Overflow to zero:** `0x80000000 × 2` → `result_o = 0x00000000`.
- **Non-MUL ignored:** `alu_ctrl_i = 4'b0010` (add), then `4'b0111` (slt), `start_i = 1` → `stall_o = 0`, `done_o` never asserted, `result_o` unchanged.
- **Async reset mid-operation:** launch `7 × 9`, assert `rst_i` mid-cycle 10 → immediately IDLE, `stall_o = 0`, `result_o = 0`. A fresh `6 × 7` after release → 42 in 33 cycles.
- **Flush, then back-to-back:**
  - Launch `4 × 4`, `flush_i` in cycle 5 → IDLE next cycle, no `done_o`, `result_o` keeps its prior value.
  - Then two consecutive muls `2 × 3` and `10 × 10` → results 6 and 100, with `done_o` pulses exactly 34 cycles apart.
